// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between icache refills,
// dcache refills and dcache dirty write-backs, one transaction in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   ic_rrdy/ic_ren/ic_raddr       icache read request handshake
//   ic_rvalid/ic_rdata            icache refill response (1-cycle pulse)
//   dc_rrdy/dc_ren/dc_raddr       dcache read request handshake
//   dc_rvalid/dc_rdata            dcache refill response (1-cycle pulse)
//   dc_wrdy/dc_wen/dc_waddr/dc_wdata  dcache write-back request handshake
//   mem_rrdy/mem_ren/mem_raddr    memory read issue (mem_ren 1-cycle pulse)
//   mem_rvalid/mem_rdata          memory read return
//   mem_wrdy/mem_wen/mem_waddr/mem_wdata  memory write issue (1-cycle pulse)
//   mem_wdone                     memory write completion pulse
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  // icache read side
  output logic              ic_rrdy,
  input  logic [3:0]        ic_ren,
  input  logic [ADDR_W-1:0] ic_raddr,
  output logic              ic_rvalid,
  output logic [LINE_W-1:0] ic_rdata,
  // dcache read side
  output logic              dc_rrdy,
  input  logic [3:0]        dc_ren,
  input  logic [ADDR_W-1:0] dc_raddr,
  output logic              dc_rvalid,
  output logic [LINE_W-1:0] dc_rdata,
  // dcache write-back side
  output logic              dc_wrdy,
  input  logic [3:0]        dc_wen,
  input  logic [ADDR_W-1:0] dc_waddr,
  input  logic [LINE_W-1:0] dc_wdata,
  // memory read port
  input  logic              mem_rrdy,
  output logic [3:0]        mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata,
  // memory write port
  input  logic              mem_wrdy,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_wdone
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t state;

  // Pending request slots
  logic              pend_ic_r;
  logic              pend_dc_r;
  logic              pend_dc_w;
  logic [ADDR_W-1:0] ic_addr_q;
  logic [ADDR_W-1:0] dc_addr_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [LINE_W-1:0] wb_data_q;

  // rr_ptr: 0 favours icache, 1 favours dcache on a read tie
  logic rr_ptr;
  // Owner of the outstanding read: 0 = icache, 1 = dcache
  logic owner_dc;

  logic ic_take;
  logic dc_take;
  logic wb_take;
  logic pick_dc;

  // Slot is free exactly when nothing is parked in it
  assign ic_rrdy = !pend_ic_r;
  assign dc_rrdy = !pend_dc_r;
  assign dc_wrdy = !pend_dc_w;

  // Any enable bit counts as a request
  assign ic_take = (|ic_ren) && !pend_ic_r;
  assign dc_take = (|dc_ren) && !pend_dc_r;
  assign wb_take = (|dc_wen) && !pend_dc_w;

  // Read winner: dcache if it is alone, or if both wait and it is favoured
  assign pick_dc = pend_dc_r && (!pend_ic_r || rr_ptr);

  // Capture, arbitration, issue and completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pend_ic_r <= 1'b0;
      pend_dc_r <= 1'b0;
      pend_dc_w <= 1'b0;
      ic_addr_q <= '0;
      dc_addr_q <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      rr_ptr    <= 1'b0;
      owner_dc  <= 1'b0;
      mem_ren   <= '0;
      mem_raddr <= '0;
      mem_wen   <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      ic_rvalid <= 1'b0;
      ic_rdata  <= '0;
      dc_rvalid <= 1'b0;
      dc_rdata  <= '0;
    end else begin
      // Pulses default low every cycle
      mem_ren   <= '0;
      mem_wen   <= '0;
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;

      // Capture only touches empty slots, so it never collides with a release
      if (ic_take) begin
        pend_ic_r <= 1'b1;
        ic_addr_q <= ic_raddr;
      end
      if (dc_take) begin
        pend_dc_r <= 1'b1;
        dc_addr_q <= dc_raddr;
      end
      if (wb_take) begin
        pend_dc_w <= 1'b1;
        wb_addr_q <= dc_waddr;
        wb_data_q <= dc_wdata;
      end

      case (state)
        IDLE: begin
          // A pending write-back blocks reads so the refill cannot overtake it
          if (pend_dc_w) begin
            if (mem_wrdy) begin
              mem_wen   <= 4'hF;
              mem_waddr <= wb_addr_q;
              mem_wdata <= wb_data_q;
              state     <= WR_WAIT;
            end
          end else if ((pend_ic_r || pend_dc_r) && mem_rrdy) begin
            mem_ren   <= 4'hF;
            mem_raddr <= pick_dc ? dc_addr_q : ic_addr_q;
            owner_dc  <= pick_dc;
            state     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (mem_rvalid) begin
            if (owner_dc) begin
              dc_rdata  <= mem_rdata;
              dc_rvalid <= 1'b1;
              pend_dc_r <= 1'b0;
              rr_ptr    <= 1'b0;
            end else begin
              ic_rdata  <= mem_rdata;
              ic_rvalid <= 1'b1;
              pend_ic_r <= 1'b0;
              rr_ptr    <= 1'b1;
            end
            state <= IDLE;
          end
        end

        WR_WAIT: begin
          if (mem_wdone) begin
            pend_dc_w <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a scoreboard; expected memory
// issues and cache refills are queued by the stimulus and consumed by a
// monitor sampling on the falling edge.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } mem_op_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              ic_rrdy, dc_rrdy, dc_wrdy;
  logic [3:0]        ic_ren, dc_ren, dc_wen;
  logic [ADDR_W-1:0] ic_raddr, dc_raddr, dc_waddr;
  logic              ic_rvalid, dc_rvalid;
  logic [LINE_W-1:0] ic_rdata, dc_rdata, dc_wdata;
  logic              mem_rrdy, mem_wrdy, mem_rvalid, mem_wdone;
  logic [3:0]        mem_ren, mem_wen;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [LINE_W-1:0] mem_rdata, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_op_t     mem_q[$];
  logic [LINE_W-1:0] ic_q[$];
  logic [LINE_W-1:0] dc_q[$];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .ic_rrdy(ic_rrdy), .ic_ren(ic_ren), .ic_raddr(ic_raddr),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
    .dc_rrdy(dc_rrdy), .dc_ren(dc_ren), .dc_raddr(dc_raddr),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_wrdy(dc_wrdy), .dc_wen(dc_wen), .dc_waddr(dc_waddr), .dc_wdata(dc_wdata),
    .mem_rrdy(mem_rrdy), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wrdy(mem_wrdy), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wdone(mem_wdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output
  always @(negedge clk) begin
    mem_op_t e;
    logic [LINE_W-1:0] d;
    if (mem_ren != 4'h0 || mem_wen != 4'h0) begin
      if (mem_q.size() == 0) unexpected("mem_issue");
      else begin
        e = mem_q.pop_front();
        chk("mem_is_write", LINE_W'(mem_wen != 4'h0), LINE_W'(e.wr));
        if (e.wr) begin
          chk("mem_wen", LINE_W'(mem_wen), LINE_W'(4'hF));
          chk("mem_waddr", LINE_W'(mem_waddr), LINE_W'(e.addr));
          chk("mem_wdata", mem_wdata, e.data);
        end else begin
          chk("mem_ren", LINE_W'(mem_ren), LINE_W'(4'hF));
          chk("mem_raddr", LINE_W'(mem_raddr), LINE_W'(e.addr));
        end
      end
    end
    if (ic_rvalid) begin
      if (ic_q.size() == 0) unexpected("ic_rvalid");
      else begin
        d = ic_q.pop_front();
        chk("ic_rdata", ic_rdata, d);
      end
    end
    if (dc_rvalid) begin
      if (dc_q.size() == 0) unexpected("dc_rvalid");
      else begin
        d = dc_q.pop_front();
        chk("dc_rdata", dc_rdata, d);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [ADDR_W-1:0] a);
    mem_op_t e;
    e.wr = 1'b0; e.addr = a; e.data = '0;
    mem_q.push_back(e);
  endtask

  // Bounded wait for the DUT to issue a memory read (wr=0) or write (wr=1)
  task automatic wait_issue(input bit wr);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wr ? (mem_wen != 4'h0) : (mem_ren != 4'h0)) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_issue: timeout waiting for %s issue, got none",
               wr ? "write" : "read");
    end
  endtask

  // Wait for a read issue and return one line of data
  task automatic read_resp(input logic [LINE_W-1:0] d);
    wait_issue(1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick(1);
    mem_rvalid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LINE_W-1:0] d_a5;
    d_a5 = {4{32'hA5A5A5A5}};
    rst = 1'b0;
    ic_ren = '0; dc_ren = '0; dc_wen = '0;
    ic_raddr = '0; dc_raddr = '0; dc_waddr = '0; dc_wdata = '0;
    mem_rrdy = 1'b1; mem_wrdy = 1'b1; mem_rvalid = 1'b0; mem_wdone = 1'b0;
    mem_rdata = '0;
    @(posedge clk); #1;

    // 1. Reset state, stray mem_rvalid in IDLE
    do_reset();
    chk("rst_ic_rrdy", LINE_W'(ic_rrdy), LINE_W'(1'b1));
    chk("rst_dc_rrdy", LINE_W'(dc_rrdy), LINE_W'(1'b1));
    chk("rst_dc_wrdy", LINE_W'(dc_wrdy), LINE_W'(1'b1));
    chk("rst_mem_ren", LINE_W'(mem_ren), LINE_W'(4'h0));
    chk("rst_mem_wen", LINE_W'(mem_wen), LINE_W'(4'h0));
    chk("rst_rvalids", LINE_W'({ic_rvalid, dc_rvalid}), LINE_W'(2'b00));
    chk("rst_ic_rdata", ic_rdata, '0);
    mem_rvalid = 1'b1; mem_rdata = d_a5;
    tick(1);
    mem_rvalid = 1'b0;
    tick(2);
    chk("idle_rvalid_ignored", LINE_W'({ic_rvalid, dc_rvalid}), LINE_W'(2'b00));

    // 2. Single icache read with latency checks
    push_rd(32'h1000);
    ic_q.push_back(d_a5);
    ic_ren = 4'hF; ic_raddr = 32'h1000;
    tick(1);
    ic_ren = '0;
    chk("ic_rrdy_busy", LINE_W'(ic_rrdy), LINE_W'(1'b0));
    chk("no_issue_at_capture", LINE_W'(mem_ren), LINE_W'(4'h0));
    tick(1);
    chk("issue_latency", LINE_W'(mem_ren), LINE_W'(4'hF));
    read_resp(d_a5);
    chk("ic_rvalid_pulse", LINE_W'(ic_rvalid), LINE_W'(1'b1));
    chk("dc_rvalid_low", LINE_W'(dc_rvalid), LINE_W'(1'b0));
    chk("dc_rdata_hold", dc_rdata, '0);
    chk("ic_rrdy_back", LINE_W'(ic_rrdy), LINE_W'(1'b1));
    tick(1);
    chk("ic_rvalid_one_cycle", LINE_W'(ic_rvalid), LINE_W'(1'b0));

    // 3. Read tie: after reset icache wins, then dcache
    do_reset();
    push_rd(32'h2000); push_rd(32'h3000);
    ic_q.push_back(128'h11);
    dc_q.push_back(128'h22);
    ic_ren = 4'h1; ic_raddr = 32'h2000;
    dc_ren = 4'h8; dc_raddr = 32'h3000;
    tick(1);
    ic_ren = '0; dc_ren = '0;
    read_resp(128'h11);
    read_resp(128'h22);
    tick(1);
    // lone icache read leaves dcache favoured for the next tie
    push_rd(32'h2100);
    ic_q.push_back(128'h33);
    ic_ren = 4'hF; ic_raddr = 32'h2100;
    tick(1);
    ic_ren = '0;
    read_resp(128'h33);
    tick(1);
    push_rd(32'h3000); push_rd(32'h2000);
    dc_q.push_back(128'h44);
    ic_q.push_back(128'h55);
    ic_ren = 4'hF; ic_raddr = 32'h2000;
    dc_ren = 4'hF; dc_raddr = 32'h3000;
    tick(1);
    ic_ren = '0; dc_ren = '0;
    read_resp(128'h44);
    read_resp(128'h55);
    tick(2);
    chk("ic_rdata_held", ic_rdata, 128'h55);

    // 4. Write-back precedes refill, blocked while mem_wrdy=0
    do_reset();
    mem_wrdy = 1'b0;
    begin
      mem_op_t w;
      w.wr = 1'b1; w.addr = 32'h4000; w.data = {4{32'hDEADBEEF}};
      mem_q.push_back(w);
    end
    push_rd(32'h5000);
    dc_q.push_back(128'h66);
    dc_wen = 4'h2; dc_waddr = 32'h4000; dc_wdata = {4{32'hDEADBEEF}};
    dc_ren = 4'hF; dc_raddr = 32'h5000;
    tick(1);
    dc_wen = '0; dc_ren = '0;
    for (int i = 0; i < 5; i++) begin
      chk("wb_blocks_all", LINE_W'({mem_ren, mem_wen}), LINE_W'(8'h00));
      tick(1);
    end
    mem_wrdy = 1'b1;
    wait_issue(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("no_read_before_wdone", LINE_W'(mem_ren), LINE_W'(4'h0));
    end
    mem_wdone = 1'b1;
    tick(1);
    mem_wdone = 1'b0;
    chk("dc_wrdy_after_wdone", LINE_W'(dc_wrdy), LINE_W'(1'b1));
    read_resp(128'h66);
    tick(2);

    // 5. Read backpressure; second request ignored while slot busy
    mem_rrdy = 1'b0;
    push_rd(32'h6000);
    ic_q.push_back(128'h77);
    ic_ren = 4'hF; ic_raddr = 32'h6000;
    tick(1);
    ic_ren = '0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_no_issue", LINE_W'(mem_ren), LINE_W'(4'h0));
      chk("bp_ic_rrdy", LINE_W'(ic_rrdy), LINE_W'(1'b0));
      if (i == 3) begin
        ic_ren = 4'hF; ic_raddr = 32'h7000;
      end
      tick(1);
      ic_ren = '0;
    end
    mem_rrdy = 1'b1;
    read_resp(128'h77);
    tick(5);

    // 6. Reset while a read is outstanding; late response ignored
    push_rd(32'h8000);
    ic_ren = 4'hF; ic_raddr = 32'h8000;
    tick(1);
    ic_ren = '0;
    wait_issue(1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 128'h99;
    mem_wdone = 1'b1;
    tick(1);
    mem_rvalid = 1'b0; mem_wdone = 1'b0;
    tick(2);
    chk("rr_rst_rvalids", LINE_W'({ic_rvalid, dc_rvalid}), LINE_W'(2'b00));
    chk("rr_rst_rdys", LINE_W'({ic_rrdy, dc_rrdy, dc_wrdy}), LINE_W'(3'b111));
    chk("rr_rst_mem_ren", LINE_W'(mem_ren), LINE_W'(4'h0));
    // back in IDLE: a fresh dcache read is served normally
    push_rd(32'h9000);
    dc_q.push_back(128'hAA);
    dc_ren = 4'hF; dc_raddr = 32'h9000;
    tick(1);
    dc_ren = '0;
    tick(1);
    chk("post_rst_issue", LINE_W'(mem_ren), LINE_W'(4'hF));
    read_resp(128'hAA);
    tick(3);

    chk("mem_q_drained", LINE_W'(mem_q.size()), '0);
    chk("ic_q_drained", LINE_W'(ic_q.size()), '0);
    chk("dc_q_drained", LINE_W'(dc_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
